tile_line_fetcher: RTL and testbench

// - Sequences the tile RAM -> tile-type lookup -> glyph ROM path once per display line.
// - On each line request, walks every tile column of that line. Reads the tile type from tile RAM,

---
 rtl/tile_pkg.sv | 42 ++++
 rtl/tile_line_buffer.sv | 31 +++
 rtl/tile_line_fetcher.sv | 136 +++++++++++++
 tb/tb_tile_line_fetcher.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared geometry, tile-type codes, glyph-ROM index lookup and fetch FSM states
// for the tile line fetcher.
package tile_pkg;

  localparam int unsigned RAM_DATA_WIDTH  = 7;
  localparam int unsigned RAM_ADDR_WIDTH  = 8;
  localparam int unsigned ROM_ADDR_WIDTH  = 12;
  localparam int unsigned ROM_DATA_WIDTH  = 16;
  localparam int unsigned TILES_PER_ROW   = 16;
  localparam int unsigned TILE_ROWS       = 12;
  localparam int unsigned TILE_PX_LOG2    = 4;
  localparam int unsigned LINE_IDX_WIDTH  = 8;
  localparam int unsigned COL_WIDTH       = $clog2(TILES_PER_ROW);
  localparam int unsigned TILE_ROW_WIDTH  = LINE_IDX_WIDTH - TILE_PX_LOG2;
  localparam int unsigned TILE_BASE_WIDTH = ROM_ADDR_WIDTH - TILE_PX_LOG2;
  localparam int unsigned OVR_CNT_WIDTH   = 8;

  typedef logic [RAM_DATA_WIDTH-1:0]  tile_code_t;
  typedef logic [TILE_BASE_WIDTH-1:0] tile_base_t;

  localparam tile_code_t TILE_EMPTY     = 7'd0;
  localparam tile_code_t TILE_LAST_CODE = 7'd87;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAM_RD,
    ST_RAM_WAIT,
    ST_ROM_RD,
    ST_ROM_WAIT,
    ST_WR,
    ST_DONE
  } fetch_state_t;

  // Glyphs sit in the ROM in code order; codes past the last defined one show the empty tile.
  function automatic tile_base_t tile_base(input tile_code_t code);
    tile_base_t base;
    if (code > TILE_LAST_CODE) base = TILE_BASE_WIDTH'(TILE_EMPTY);
    else                       base = TILE_BASE_WIDTH'(code);
    return base;
  endfunction

endpackage

// File: rtl/tile_line_buffer.sv
// Ping-pong glyph line buffer: two banks of TILES_PER_ROW glyph rows, one write
// port and one registered read port, each with its own bank select.
module tile_line_buffer
  import tile_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic                      wr_bank,
  input  logic [COL_WIDTH-1:0]      wr_col,
  input  logic [ROM_DATA_WIDTH-1:0] wr_data,
  input  logic                      rd_bank,
  input  logic [COL_WIDTH-1:0]      rd_col,
  output logic [ROM_DATA_WIDTH-1:0] rd_data
);

  logic [1:0][TILES_PER_ROW-1:0][ROM_DATA_WIDTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem     <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_bank][wr_col] <= wr_data;
      // Columns beyond the line width read as blank.
      if (32'(rd_col) >= TILES_PER_ROW) rd_data <= '0;
      else                              rd_data <= mem[rd_bank][rd_col];
    end
  end

endmodule

// File: rtl/tile_line_fetcher.sv
// Per-line tile fetch: tile RAM -> tile-type lookup -> glyph ROM -> ping-pong line buffer.
// Define TILE_FETCH_OVERRUN_CNT_EN to build the saturating overrun counter on overrun_cnt_o.
module tile_line_fetcher
  import tile_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      line_req_i,
  input  logic [LINE_IDX_WIDTH-1:0] line_idx_i,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [RAM_DATA_WIDTH-1:0] ram_data_i,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [ROM_DATA_WIDTH-1:0] rom_data_i,
  input  logic [COL_WIDTH-1:0]      rd_col_i,
  output logic [ROM_DATA_WIDTH-1:0] rd_data_o,
  output logic                      busy_o,
  output logic                      line_done_o,
  output logic                      overrun_o,
  output logic [OVR_CNT_WIDTH-1:0]  overrun_cnt_o
);

  fetch_state_t              state;
  logic [COL_WIDTH-1:0]      col;
  logic [COL_WIDTH-1:0]      next_col;
  logic [TILE_ROW_WIDTH-1:0] tile_row;
  logic [TILE_PX_LOG2-1:0]   glyph_row;
  logic                      wr_bank;
  logic [TILE_ROW_WIDTH-1:0] req_row;
  logic [TILE_PX_LOG2-1:0]   req_glyph;
  logic                      req_in_range;
  logic                      req_ignored;
  logic                      last_col;
  logic                      buf_wr_en;
  logic [ROM_DATA_WIDTH-1:0] buf_wr_data;

  assign req_row      = line_idx_i[LINE_IDX_WIDTH-1:TILE_PX_LOG2];
  assign req_glyph    = line_idx_i[TILE_PX_LOG2-1:0];
  assign req_in_range = (32'(req_row) < TILE_ROWS);
  assign req_ignored  = line_req_i && (state != ST_IDLE);
  assign next_col     = col + 1'b1;
  assign last_col     = (col == COL_WIDTH'(TILES_PER_ROW - 1));

  // ROM data is valid in ROM_WAIT and is written on that cycle's closing edge, which keeps
  // a column at four cycles; WR is the one-cycle zero fill used for off-screen lines.
  assign buf_wr_en   = (state == ST_ROM_WAIT) || (state == ST_WR);
  assign buf_wr_data = (state == ST_ROM_WAIT) ? rom_data_i : '0;

  function automatic logic [RAM_ADDR_WIDTH-1:0] tile_addr(input logic [TILE_ROW_WIDTH-1:0] row,
                                                          input logic [COL_WIDTH-1:0]      c);
    return RAM_ADDR_WIDTH'(32'(row) * TILES_PER_ROW + 32'(c));
  endfunction

  // Fetch sequencer; RAM/ROM addresses are non-zero only in their issue cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      col         <= '0;
      tile_row    <= '0;
      glyph_row   <= '0;
      wr_bank     <= 1'b0;
      ram_addr_o  <= '0;
      rom_addr_o  <= '0;
      busy_o      <= 1'b0;
      line_done_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      ram_addr_o  <= '0;
      rom_addr_o  <= '0;
      line_done_o <= 1'b0;
      if (req_ignored) overrun_o <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (line_req_i) begin
            tile_row  <= req_row;
            glyph_row <= req_glyph;
            col       <= '0;
            busy_o    <= 1'b1;
            if (req_in_range) begin
              state      <= ST_RAM_RD;
              ram_addr_o <= tile_addr(req_row, '0);
            end else begin
              state <= ST_WR;
            end
          end
        end
        ST_RAM_RD:   state <= ST_RAM_WAIT;
        ST_RAM_WAIT: begin
          state      <= ST_ROM_RD;
          rom_addr_o <= {tile_base(ram_data_i), glyph_row};
        end
        ST_ROM_RD:   state <= ST_ROM_WAIT;
        ST_ROM_WAIT, ST_WR: begin
          if (last_col) begin
            state       <= ST_DONE;
            busy_o      <= 1'b0;
            line_done_o <= 1'b1;
            wr_bank     <= ~wr_bank;
          end else begin
            col <= next_col;
            if (state == ST_ROM_WAIT) begin
              state      <= ST_RAM_RD;
              ram_addr_o <= tile_addr(tile_row, next_col);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TILE_FETCH_OVERRUN_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_cnt_o <= '0;
    end else if (req_ignored && (overrun_cnt_o != {OVR_CNT_WIDTH{1'b1}})) begin
      overrun_cnt_o <= overrun_cnt_o + 1'b1;
    end
  end
`else
  assign overrun_cnt_o = '0;
`endif

  tile_line_buffer u_line_buffer (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_en   (buf_wr_en),
    .wr_bank (wr_bank),
    .wr_col  (col),
    .wr_data (buf_wr_data),
    .rd_bank (~wr_bank),
    .rd_col  (rd_col_i),
    .rd_data (rd_data_o)
  );

endmodule

// File: tb/tb_tile_line_fetcher.sv
// Scoreboard bench for tile_line_fetcher with behavioural sync tile RAM and glyph ROM.
`timescale 1ns/1ps
module tb_tile_line_fetcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_req;
  logic [7:0]  line_idx;
  logic [7:0]  ram_addr;
  logic [6:0]  ram_data;
  logic [11:0] rom_addr;
  logic [15:0] rom_data;
  logic [3:0]  rd_col;
  logic [15:0] rd_data;
  logic        busy;
  logic        line_done;
  logic        overrun;
  logic [7:0]  overrun_cnt;

  logic [6:0]  ram_mem [256];
  logic [31:0] q_ram [$];
  logic [31:0] q_rom [$];
  logic [31:0] q_word [$];
  int          n_cmp = 0;
  int          n_bad = 0;

`ifdef TILE_FETCH_OVERRUN_CNT_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  tile_line_fetcher dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .line_req_i    (line_req),
    .line_idx_i    (line_idx),
    .ram_addr_o    (ram_addr),
    .ram_data_i    (ram_data),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .rd_col_i      (rd_col),
    .rd_data_o     (rd_data),
    .busy_o        (busy),
    .line_done_o   (line_done),
    .overrun_o     (overrun),
    .overrun_cnt_o (overrun_cnt)
  );

  function automatic logic [15:0] rom_word(input logic [11:0] a);
    return {a, 4'h0} ^ 16'hC3A5;
  endfunction

  function automatic logic [7:0] ref_base(input logic [6:0] code);
    return (code <= 7'd87) ? {1'b0, code} : 8'd0;
  endfunction

  // One-cycle-latency tile RAM and glyph ROM
  always @(posedge clk) begin
    ram_data <= ram_mem[ram_addr];
    rom_data <= rom_word(rom_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return OVR_EN ? 32'(n) : 32'd0;
  endfunction

  // Request one line, check strobes/timing as they appear, then read the display bank back.
  task automatic fetch_line(input logic [7:0] idx, input int ov_at, input string tag);
    logic [3:0]  trow;
    logic [3:0]  grow;
    logic [7:0]  a;
    logic [11:0] ra;
    bit          inr;
    int          done_at;
    int          busy_cnt;
    int          strobes;
    trow = idx[7:4];
    grow = idx[3:0];
    inr  = (trow < 4'd12);
    q_ram.delete();
    q_rom.delete();
    q_word.delete();
    for (int c = 0; c < 16; c++) begin
      if (inr) begin
        a  = 8'(32'(trow) * 16 + c);
        ra = {ref_base(ram_mem[a]), grow};
        q_ram.push_back(32'(a));
        q_rom.push_back(32'(ra));
        q_word.push_back(32'(rom_word(ra)));
      end else begin
        q_word.push_back(32'd0);
      end
    end
    line_idx = idx;
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    done_at  = -1;
    busy_cnt = 0;
    strobes  = 0;
    for (int k = 1; k <= 100; k++) begin
      if (busy) busy_cnt++;
      if (inr && k <= 64 && (k % 4) == 1) check_eq({tag, " ram_addr"}, 32'(ram_addr), q_ram.pop_front());
      if (inr && k <= 64 && (k % 4) == 3) check_eq({tag, " rom_addr"}, 32'(rom_addr), q_rom.pop_front());
      if (!inr && (ram_addr != 8'd0 || rom_addr != 12'd0)) strobes++;
      if (k == ov_at) line_req = 1'b1;
      if (line_done) begin
        done_at = k;
        break;
      end
      @(negedge clk);
      line_req = 1'b0;
    end
    @(negedge clk);
    line_req = 1'b0;
    check_eq({tag, " done cycle"}, 32'(done_at), inr ? 32'd65 : 32'd17);
    check_eq({tag, " busy cycles"}, 32'(busy_cnt), inr ? 32'd64 : 32'd16);
    check_eq({tag, " idle after done"}, 32'(busy), 32'd0);
    if (!inr) check_eq({tag, " strobes"}, 32'(strobes), 32'd0);
    for (int c = 0; c < 16; c++) begin
      rd_col = 4'(c);
      @(negedge clk);
      check_eq($sformatf("%s col%0d", tag, c), 32'(rd_data), q_word.pop_front());
    end
  endtask

  initial begin
    int pulses;
    int wait_cyc;
    rst      = 1'b1;
    line_req = 1'b0;
    line_idx = 8'd0;
    rd_col   = 4'd0;
    for (int i = 0; i < 256; i++) ram_mem[i] = 7'd7;
    repeat (3) @(negedge clk);
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset done", 32'(line_done), 32'd0);
    check_eq("reset overrun", 32'(overrun), 32'd0);
    check_eq("reset overrun_cnt", 32'(overrun_cnt), 32'd0);
    check_eq("reset ram_addr", 32'(ram_addr), 32'd0);
    check_eq("reset rom_addr", 32'(rom_addr), 32'd0);
    check_eq("reset rd_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // All circles on tile row 0
    fetch_line(8'd0, 0, "t1");
    check_eq("t1 overrun", 32'(overrun), 32'd0);

    // Mixed row 2, glyph row 5, column 3 holds type 22
    for (int i = 32; i < 48; i++) ram_mem[i] = 7'((i * 13) % 88);
    ram_mem[35] = 7'd22;
    fetch_line(8'd37, 0, "t2");

    // Off-screen line
    fetch_line(8'd200, 0, "t3");

    // Code map edges on row 1, glyph row 9
    for (int i = 16; i < 32; i++) ram_mem[i] = 7'((i * 11) % 128);
    ram_mem[16] = 7'd100;
    ram_mem[17] = 7'd87;
    ram_mem[18] = 7'd88;
    ram_mem[19] = 7'd127;
    ram_mem[20] = 7'd0;
    fetch_line(8'h19, 0, "t4");

    // Last on-screen tile row
    fetch_line(8'd191, 0, "t4b");

    // Overrun mid-fetch, then a request landing in the DONE cycle
    fetch_line(8'd37, 10, "t5");
    check_eq("t5 overrun", 32'(overrun), 32'd1);
    check_eq("t5 overrun_cnt", 32'(overrun_cnt), exp_cnt(1));
    fetch_line(8'd200, 17, "t6");
    check_eq("t6 overrun_cnt", 32'(overrun_cnt), exp_cnt(2));

    // Reset mid-fetch at cycle 30
    line_idx = 8'd37;
    line_req = 1'b1;
    @(negedge clk);
    line_req = 1'b0;
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t7 busy after rst", 32'(busy), 32'd0);
    rst    = 1'b0;
    rd_col = 4'd3;
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (line_done) pulses++;
    end
    check_eq("t7 no line_done", 32'(pulses), 32'd0);
    check_eq("t7 rd_data", 32'(rd_data), 32'd0);
    check_eq("t7 overrun", 32'(overrun), 32'd0);
    check_eq("t7 overrun_cnt", 32'(overrun_cnt), 32'd0);

    // Hold the request high long enough to saturate the counter
    line_idx = 8'd0;
    line_req = 1'b1;
    repeat (400) @(negedge clk);
    line_req = 1'b0;
    wait_cyc = 0;
    while (busy && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
    end
    check_eq("t8 busy drains", 32'(busy), 32'd0);
    check_eq("t8 overrun", 32'(overrun), 32'd1);
    check_eq("t8 overrun_cnt sat", 32'(overrun_cnt), exp_cnt(255));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
